rf_op_sequencer: RTL and testbench

- Initiator-side master for the 8-entry × 8-bit two-read/one-write register file (sync write, combinational read, entry 0 reads zero).
- Accepts one three-operand command at a time over a valid/ready handshake.
- Reads source operands via RX/RY, computes an ALU result, writes it back via WEN/RW/busW, then returns the result on a response handshake.
- Sits between a command source (bench or future decoder) and register_file.

---
 rtl/rf_seq_pkg.sv | 26 ++
 rtl/rf_op_sequencer_if.sv | 50 +++++
 rtl/rf_seq_alu.sv | 37 +++
 rtl/rf_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_rf_op_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/rf_seq_pkg.sv
// Shared constants for the register-file op sequencer.
// Optional readback checking is enabled with SEQ_READBACK_EN.
package rf_seq_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLTU = 3'd5;
  localparam logic [2:0] OP_LI   = 3'd6;
  localparam logic [2:0] OP_RD   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_VERIFY,
    S_RESP
  } state_t;

endpackage

// File: rtl/rf_op_sequencer_if.sv
// Command, response and register-file port bundle of the sequencer.
// master = sequencer side, slave = command source / register file side.
interface rf_op_sequencer_if
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs;
  logic [AW-1:0] cmd_rt;
  logic [DW-1:0] cmd_imm;

  logic          WEN;
  logic [AW-1:0] RW;
  logic [DW-1:0] busW;
  logic [AW-1:0] RX;
  logic [AW-1:0] RY;
  logic [DW-1:0] busX;
  logic [DW-1:0] busY;

  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_carry;
  logic          resp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_rd,
    input  cmd_rs, cmd_rt, cmd_imm,
    input  busX, busY, resp_ready,
    output cmd_ready, WEN, RW, busW,
    output RX, RY, resp_valid,
    output resp_data, resp_carry, resp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd,
    output cmd_rs, cmd_rt, cmd_imm,
    output busX, busY, resp_ready,
    input  cmd_ready, WEN, RW, busW,
    input  RX, RY, resp_valid,
    input  resp_data, resp_carry, resp_err
  );

endinterface

// File: rtl/rf_seq_alu.sv
// Combinational ALU of the sequencer; carry is the ADD carry
// or the SUB borrow, zero for all other ops.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] res,
  output logic          carry
);

  logic [DW:0] sum;
  logic [DW:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    unique case (op)
      OP_ADD:  {carry, res} = sum;
      OP_SUB:  {carry, res} = dif;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLTU: res = {{(DW-1){1'b0}}, a < b};
      OP_LI:   res = imm;
      OP_RD:   res = a;
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Read / execute / write-back sequencer driving a 2R1W register file.
// Define SEQ_READBACK_EN to add a VERIFY state that reads rd back.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input logic               Clk,
  input logic               Rst,
  rf_op_sequencer_if.master bus
);

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] rw_q, rw_d;
  logic [DW-1:0] busw_q, busw_d;
  logic [AW-1:0] rx_q, rx_d;
  logic [AW-1:0] ry_q, ry_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rcarry_q, rcarry_d;
  logic          rerr_q, rerr_d;

  logic [DW-1:0] alu_res;
  logic          alu_carry;

  rf_seq_alu #(.DW(DW)) u_alu (
    .op    (op_q),
    .a     (opa_q),
    .b     (opb_q),
    .imm   (imm_q),
    .res   (alu_res),
    .carry (alu_carry)
  );

  assign bus.cmd_ready  = (state_q == S_IDLE) && !Rst;
  assign bus.WEN        = wen_q;
  assign bus.RW         = rw_q;
  assign bus.busW       = busw_q;
  assign bus.RX         = rx_q;
  assign bus.RY         = ry_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_data  = rdata_q;
  assign bus.resp_carry = rcarry_q;
`ifdef SEQ_READBACK_EN
  assign bus.resp_err   = rerr_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    wen_d    = 1'b0;
    rw_d     = rw_q;
    busw_d   = busw_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rcarry_d = rcarry_q;
    rerr_d   = rerr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          op_d    = bus.cmd_op;
          rd_d    = bus.cmd_rd;
          imm_d   = bus.cmd_imm;
          rx_d    = bus.cmd_rs;
          ry_d    = bus.cmd_rt;
          rerr_d  = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        opa_d   = bus.busX;
        opb_d   = bus.busY;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        rdata_d  = alu_res;
        rcarry_d = alu_carry;
        if (op_q == OP_RD) begin
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          wen_d   = 1'b1;
          rw_d    = rd_q;
          busw_d  = alu_res;
          state_d = S_WB;
        end
      end
      S_WB: begin
`ifdef SEQ_READBACK_EN
        rx_d     = rd_q;
        state_d  = S_VERIFY;
`else
        rvalid_d = 1'b1;
        state_d  = S_RESP;
`endif
      end
`ifdef SEQ_READBACK_EN
      S_VERIFY: begin
        // entry 0 never stores, so it must read back as zero
        rerr_d   = bus.busX !=
                   ((rd_q == '0) ? '0 : rdata_q);
        rvalid_d = 1'b1;
        state_d  = S_RESP;
      end
`endif
      S_RESP: begin
        if (bus.resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      wen_q    <= 1'b0;
      rw_q     <= '0;
      busw_q   <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rcarry_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      wen_q    <= wen_d;
      rw_q     <= rw_d;
      busw_q   <= busw_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rcarry_q <= rcarry_d;
      rerr_q   <= rerr_d;
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Randomized bench for rf_op_sequencer with a behavioural model.
// Honours SEQ_READBACK_EN for the write-op latency.
module tb_rf_op_sequencer;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  rf_op_sequencer_if #(.DW(8), .AW(3)) bus ();

  rf_op_sequencer #(.DW(8), .AW(3)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  logic [7:0] rf_mem  [8] = '{default: 8'd0};
  int         ref_reg [8] = '{default: 0};

  always @(posedge Clk)
    if (bus.WEN && bus.RW != 3'd0) rf_mem[bus.RW] <= bus.busW;

  assign bus.busX = (bus.RX == 3'd0) ? 8'd0 : rf_mem[bus.RX];
  assign bus.busY = (bus.RY == 3'd0) ? 8'd0 : rf_mem[bus.RY];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic ref_exec(input int op, input int a,
                          input int b, input int imm,
                          output int res, output int cy);
    cy = 0;
    case (op)
      0: begin res = (a + b) % 256; cy = (a + b > 255); end
      1: begin res = (a - b + 256) % 256; cy = (a < b); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (a < b) ? 1 : 0;
      6: res = imm;
      default: res = a;
    endcase
  endtask

  // Must be entered on a negedge; leaves on the negedge after
  // the response is taken, with the sequencer back in IDLE.
  task automatic do_cmd(input int op, input int rd,
                        input int rs, input int rt,
                        input int imm, input int hold);
    int a, b, res, cy, cyc, wens, lat, n;
    a = (rs == 0) ? 0 : ref_reg[rs];
    b = (rt == 0) ? 0 : ref_reg[rt];
    ref_exec(op, a, b, imm, res, cy);
    lat = (op == 7) ? 3 : 4;
`ifdef SEQ_READBACK_EN
    if (op != 7) lat = 5;
`endif
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("cmd_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_rd    = 3'(rd);
    bus.cmd_rs    = 3'(rs);
    bus.cmd_rt    = 3'(rt);
    bus.cmd_imm   = 8'(imm);
    bus.resp_ready = 1'b0;
    @(negedge Clk);
    bus.cmd_valid = 1'b0;
    cyc  = 1;
    wens = 0;
    while (!bus.resp_valid && cyc < 12) begin
      if (bus.WEN) begin
        wens++;
        chk("RW", 32'(bus.RW), 32'(rd));
        chk("busW", 32'(bus.busW), 32'(res));
      end
      @(negedge Clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    chk("wen_pulses", 32'(wens), (op == 7) ? 0 : 1);
    chk("resp_data", 32'(bus.resp_data), 32'(res));
    chk("resp_carry", 32'(bus.resp_carry), 32'(cy));
    chk("resp_err", 32'(bus.resp_err), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk("hold_valid", 32'(bus.resp_valid), 1);
      chk("hold_data", 32'(bus.resp_data), 32'(res));
      chk("hold_rdy", 32'(bus.cmd_ready), 0);
    end
    bus.resp_ready = 1'b1;
    @(negedge Clk);
    chk("resp_drop", 32'(bus.resp_valid), 0);
    chk("idle_rdy", 32'(bus.cmd_ready), 1);
    bus.resp_ready = 1'b0;
    if (op != 7 && rd != 0) ref_reg[rd] = res;
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_rd     = '0;
    bus.cmd_rs     = '0;
    bus.cmd_rt     = '0;
    bus.cmd_imm    = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_rdy", 32'(bus.cmd_ready), 0);
    chk("rst_wen", 32'(bus.WEN), 0);
    chk("rst_valid", 32'(bus.resp_valid), 0);
    chk("rst_data", 32'(bus.resp_data), 0);
    chk("rst_rxry", {bus.RX, bus.RY, bus.RW}, 0);
    Rst = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(bus.cmd_ready), 1);
    @(negedge Clk);

    do_cmd(6, 1, 0, 0, 5, 0);
    do_cmd(7, 0, 1, 0, 0, 0);
    do_cmd(6, 2, 0, 0, 250, 0);
    do_cmd(0, 3, 2, 1, 0, 0);
    do_cmd(0, 3, 3, 1, 0, 0);
    do_cmd(1, 4, 1, 2, 0, 0);
    do_cmd(5, 5, 1, 2, 0, 0);
    do_cmd(6, 0, 0, 0, 7, 0);
    do_cmd(7, 0, 0, 0, 0, 0);
    do_cmd(2, 6, 2, 1, 0, 3);
    chk("r3_value", 32'(rf_mem[3]), 4);

    for (int k = 0; k < 40; k++)
      do_cmd(int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)));

    // Reset while WB is in progress: the write must not land.
    ref_exec(6, 0, 0, 0, n_tests, n_tests);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd6;
    bus.cmd_rd    = 3'd1;
    bus.cmd_imm   = ~8'(ref_reg[1]);
    @(negedge Clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge Clk);
    chk("wb_wen", 32'(bus.WEN), 1);
    #1 Rst = 1'b1;
    #1;
    chk("abort_wen", 32'(bus.WEN), 0);
    chk("abort_out", {bus.RW, bus.busW, bus.RX, bus.RY}, 0);
    chk("abort_resp", {bus.resp_valid, bus.resp_data,
                       bus.resp_carry, bus.resp_err}, 0);
    chk("abort_rdy", 32'(bus.cmd_ready), 0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("abort_idle", 32'(bus.cmd_ready), 1);
    chk("abort_keep", 32'(rf_mem[1]), 32'(ref_reg[1]));
    @(negedge Clk);

    for (int r = 0; r < 8; r++)
      chk("regfile", 32'(rf_mem[r]), 32'(ref_reg[r]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
